// File: rtl/trb_mem_ctrl.sv
// trb_mem_ctrl: trace-buffer memory controller (ring capture / stream FIFO).
// Ports: Tracer store/load, trigger, host access, status (DONE, TRG_*, WPTR, FILL).
module trb_mem_ctrl #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int EPOS_BITS = $clog2(WIDTH)
) (
  input  logic                     FPGA_CLK_I,
  input  logic                     RST_I,
  input  logic                     ARM_I,
  input  logic                     MODE_I,
  input  logic [$clog2(DEPTH)-1:0] TRG_DELAY_I,
  input  logic                     STORE_I,
  input  logic [WIDTH-1:0]         STORE_DATA_I,
  output logic                     STORE_PERM_O,
  input  logic                     TRG_EVENT_I,
  input  logic [EPOS_BITS-1:0]     EVENT_POS_I,
  output logic                     TRG_DELAYED_O,
  input  logic                     LOAD_REQUEST_I,
  output logic                     LOAD_GRANT_O,
  output logic [WIDTH-1:0]         LOAD_DATA_O,
  input  logic                     HOST_REQ_I,
  input  logic                     HOST_WE_I,
  input  logic [$clog2(DEPTH)-1:0] HOST_ADDR_I,
  input  logic [WIDTH-1:0]         HOST_DATA_I,
  output logic                     HOST_ACK_O,
  output logic [WIDTH-1:0]         HOST_DATA_O,
  output logic                     DONE_O,
  output logic [$clog2(DEPTH)-1:0] TRG_ADDR_O,
  output logic [EPOS_BITS-1:0]     TRG_POS_O,
  output logic [$clog2(DEPTH)-1:0] WPTR_O,
  output logic [$clog2(DEPTH):0]   FILL_O
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_POST, S_DONE, S_STREAM
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q, cnt_q, dly_q;
  logic [AW:0]   fill_q;

  logic arm_go, store_go, trg_go, load_go, host_go;

  always_ff @(posedge FPGA_CLK_I) begin
    if (RST_I) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // One memory access per cycle: store > load > host.
  always_comb begin
    state_d  = state_q;
    arm_go   = 1'b0;
    store_go = 1'b0;
    trg_go   = 1'b0;
    load_go  = 1'b0;
    host_go  = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        arm_go  = ARM_I;
        // A re-arm wins over a pending host access.
        host_go = HOST_REQ_I && !ARM_I;
        if (ARM_I) state_d = MODE_I ? S_STREAM : S_CAPTURE;
      end
      S_CAPTURE: begin
        store_go = STORE_I;
        if (TRG_EVENT_I) begin
          trg_go  = 1'b1;
          // A store in the trigger cycle is the first post-trigger word.
          state_d = (STORE_I && dly_q == '0) ? S_DONE : S_POST;
        end
      end
      S_POST: begin
        store_go = STORE_I;
        if (STORE_I && cnt_q == '0) state_d = S_DONE;
      end
      S_STREAM: begin
        load_go = LOAD_REQUEST_I && fill_q != '0 && !LOAD_GRANT_O;
        host_go = HOST_REQ_I && !load_go
                  && (!HOST_WE_I || fill_q != FULL);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge FPGA_CLK_I) begin
    if (RST_I) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      fill_q       <= '0;
      cnt_q        <= '0;
      dly_q        <= '0;
      TRG_ADDR_O   <= '0;
      TRG_POS_O    <= '0;
      LOAD_GRANT_O <= 1'b0;
      LOAD_DATA_O  <= '0;
      HOST_ACK_O   <= 1'b0;
      HOST_DATA_O  <= '0;
    end else begin
      LOAD_GRANT_O <= load_go;
      HOST_ACK_O   <= host_go;
      if (arm_go) begin
        wptr_q <= '0;
        rptr_q <= '0;
        fill_q <= '0;
        dly_q  <= TRG_DELAY_I;
      end
      if (store_go) wptr_q <= wptr_q + 1'b1;
      if (trg_go) begin
        TRG_ADDR_O <= wptr_q;
        TRG_POS_O  <= EVENT_POS_I;
        cnt_q      <= STORE_I ? dly_q - 1'b1 : dly_q;
      end else if (state_q == S_POST && store_go && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (load_go) begin
        LOAD_DATA_O <= mem[rptr_q];
        rptr_q      <= rptr_q + 1'b1;
        fill_q      <= fill_q - 1'b1;
      end
      if (host_go) begin
        if (state_q == S_STREAM) begin
          if (HOST_WE_I) begin
            wptr_q <= wptr_q + 1'b1;
            fill_q <= fill_q + 1'b1;
          end else begin
            HOST_DATA_O <= '0;
          end
        end else if (!HOST_WE_I) begin
          HOST_DATA_O <= mem[HOST_ADDR_I];
        end
      end
    end
  end

  // Buffer contents survive reset.
  always_ff @(posedge FPGA_CLK_I) begin
    if (!RST_I) begin
      if (store_go)
        mem[wptr_q] <= STORE_DATA_I;
      else if (host_go && HOST_WE_I)
        mem[state_q == S_STREAM ? wptr_q : HOST_ADDR_I] <= HOST_DATA_I;
    end
  end

  assign STORE_PERM_O  = state_q == S_CAPTURE || state_q == S_POST;
  assign DONE_O        = state_q == S_DONE;
  assign TRG_DELAYED_O = state_q == S_DONE;
  assign WPTR_O        = wptr_q;
  assign FILL_O        = fill_q;

endmodule

// File: tb/tb_trb_mem_ctrl.sv
// tb_trb_mem_ctrl: scoreboard bench for trb_mem_ctrl.
// Stimulus pushes expected host/load data; a negedge monitor pops and compares.
module tb_trb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arm = 1'b0;
  logic        mode = 1'b0;
  logic [3:0]  dly = '0;
  logic        store = 1'b0;
  logic [31:0] sdata = '0;
  logic        perm;
  logic        trg = 1'b0;
  logic [4:0]  epos = '0;
  logic        trg_dly;
  logic        lreq = 1'b0;
  logic        lgnt;
  logic [31:0] ldata;
  logic        hreq = 1'b0;
  logic        hwe = 1'b0;
  logic [3:0]  haddr = '0;
  logic [31:0] hwdata = '0;
  logic        hack;
  logic [31:0] hrdata;
  logic        done;
  logic [3:0]  taddr;
  logic [4:0]  tpos;
  logic [3:0]  wptr;
  logic [4:0]  fill;

  int total = 0;
  int bad = 0;
  int ngrant = 0;
  bit prev_g = 1'b0;
  logic [31:0] hd_model = '0;
  logic [31:0] host_q[$];
  logic [31:0] load_q[$];

  always #5 clk = ~clk;

  trb_mem_ctrl dut (
    .FPGA_CLK_I(clk), .RST_I(rst), .ARM_I(arm), .MODE_I(mode),
    .TRG_DELAY_I(dly), .STORE_I(store), .STORE_DATA_I(sdata),
    .STORE_PERM_O(perm), .TRG_EVENT_I(trg), .EVENT_POS_I(epos),
    .TRG_DELAYED_O(trg_dly), .LOAD_REQUEST_I(lreq),
    .LOAD_GRANT_O(lgnt), .LOAD_DATA_O(ldata), .HOST_REQ_I(hreq),
    .HOST_WE_I(hwe), .HOST_ADDR_I(haddr), .HOST_DATA_I(hwdata),
    .HOST_ACK_O(hack), .HOST_DATA_O(hrdata), .DONE_O(done),
    .TRG_ADDR_O(taddr), .TRG_POS_O(tpos), .WPTR_O(wptr), .FILL_O(fill)
  );

  function automatic void chk(string nm, logic [63:0] a, logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, a, e);
    end
  endfunction

  always @(negedge clk) begin
    if (hack) begin
      if (host_q.size() == 0) chk("host_unexp_ack", 1, 0);
      else chk("host_data", hrdata, host_q.pop_front());
    end
    if (lgnt) begin
      ngrant++;
      if (load_q.size() == 0) chk("load_unexp_grant", 1, 0);
      else chk("load_data", ldata, load_q.pop_front());
      if (prev_g) chk("grant_back2back", 1, 0);
    end
    prev_g = lgnt;
  end

  task automatic host_acc(input bit we, input logic [3:0] a,
                          input logic [31:0] d, input logic [31:0] e,
                          input string nm);
    int n;
    host_q.push_back(we ? hd_model : e);
    if (!we) hd_model = e;
    @(negedge clk);
    hreq = 1'b1; hwe = we; haddr = a; hwdata = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!hack && n < 50);
    hreq = 1'b0; hwe = 1'b0;
    chk({nm, "_lat"}, n, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_perm", perm, 0);
    chk("rst_done", done, 0);
    chk("rst_trgdly", trg_dly, 0);
    chk("rst_wptr", wptr, 0);
    chk("rst_fill", fill, 0);
    chk("rst_ack", hack, 0);
    chk("rst_grant", lgnt, 0);

    // Reset while in POST with cnt=5
    @(negedge clk); arm = 1; mode = 0; dly = 4'd5;
    @(negedge clk); arm = 0; store = 1; sdata = 32'h99;
    @(negedge clk); store = 0; trg = 1;
    @(negedge clk); trg = 0;
    chk("post_perm", perm, 1);
    chk("post_wptr", wptr, 1);
    chk("post_taddr", taddr, 1);
    rst = 1;
    @(negedge clk); rst = 0;
    chk("midrst_perm", perm, 0);
    chk("midrst_trgdly", trg_dly, 0);
    chk("midrst_done", done, 0);
    chk("midrst_wptr", wptr, 0);
    chk("midrst_taddr", taddr, 0);

    host_acc(1, 4'd6, 32'h55, 0, "idle_wr");

    // Basic capture, delay 3, trigger on 3rd store
    @(negedge clk); arm = 1; mode = 0; dly = 4'd3; epos = 5'd7;
    @(negedge clk); arm = 0;
    chk("cap_perm", perm, 1);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 5) chk("cap_not_done_early", done, 0);
      store = 1; sdata = 32'hA0 + i; trg = (i >= 2);
    end
    @(negedge clk); store = 0; trg = 0;
    chk("cap_done", done, 1);
    chk("cap_trgdly", trg_dly, 1);
    chk("cap_perm_off", perm, 0);
    chk("cap_taddr", taddr, 2);
    chk("cap_tpos", tpos, 7);
    chk("cap_wptr", wptr, 6);
    store = 1; sdata = 32'hEE;
    @(negedge clk); store = 0;
    chk("cap_7th_wptr", wptr, 6);
    for (int i = 0; i < 6; i++)
      host_acc(0, 4'(i), 0, 32'hA0 + i, "cap_rd");
    host_acc(0, 4'd6, 0, 32'h55, "cap_rd6");

    // Wrap: delay 15, 20 pre-trigger stores; loads must not be granted
    @(negedge clk); arm = 1; mode = 0; dly = 4'd15; epos = 5'd3;
    @(negedge clk); arm = 0; lreq = 1;
    chk("wrap_trgdly_cleared", trg_dly, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); store = 1; sdata = 32'hB00 + i;
    end
    @(negedge clk); store = 0; trg = 1;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      if (j == 15) chk("wrap_not_done_early", done, 0);
      store = 1; sdata = 32'hC00 + j;
    end
    @(negedge clk); store = 0; trg = 0; lreq = 0;
    chk("wrap_done", done, 1);
    chk("wrap_taddr", taddr, 4);
    chk("wrap_tpos", tpos, 3);
    chk("wrap_wptr", wptr, 4);
    host_acc(0, 4'd4, 0, 32'hC00, "wrap_rd4");
    host_acc(0, 4'd3, 0, 32'hC0F, "wrap_rd3");

    // Host read pending across re-arm
    @(negedge clk);
    arm = 1; mode = 0; dly = 4'd0;
    hreq = 1; hwe = 0; haddr = 4'd5;
    host_q.push_back(32'hC01); hd_model = 32'hC01;
    @(negedge clk); arm = 0;
    chk("rearm_trgdly", trg_dly, 0);
    chk("rearm_noack0", hack, 0);
    repeat (3) begin
      @(negedge clk);
      chk("rearm_noack", hack, 0);
    end
    store = 1; sdata = 32'hD0; trg = 1;
    @(negedge clk); store = 0; trg = 0;
    chk("rearm_done", done, 1);
    chk("rearm_noack_done", hack, 0);
    @(negedge clk);
    chk("rearm_ack", hack, 1);
    hreq = 0;

    // Stream FIFO
    @(negedge clk); arm = 1; mode = 1;
    @(negedge clk); arm = 0;
    chk("strm_perm", perm, 0);
    host_acc(1, 4'd9, 32'h11, 0, "push");
    host_acc(1, 4'd9, 32'h22, 0, "push");
    host_acc(1, 4'd9, 32'h33, 0, "push");
    chk("strm_fill3", fill, 3);
    host_acc(0, 4'd1, 0, 32'h0, "strm_rd");
    load_q.push_back(32'h11);
    load_q.push_back(32'h22);
    load_q.push_back(32'h33);
    lreq = 1;
    repeat (10) @(negedge clk);
    lreq = 0;
    chk("strm_fill0", fill, 0);
    chk("strm_grants", ngrant, 3);

    // Full FIFO stall and load-over-host priority
    for (int i = 0; i < 16; i++)
      host_acc(1, 4'd0, 32'h100 + i, 0, "fill");
    chk("full_fill16", fill, 16);
    host_q.push_back(hd_model);
    @(negedge clk); hreq = 1; hwe = 1; hwdata = 32'h200;
    repeat (3) begin
      @(negedge clk);
      chk("full_stall", hack, 0);
    end
    lreq = 1;
    load_q.push_back(32'h100);
    @(negedge clk); lreq = 0;
    chk("prio_grant", lgnt, 1);
    chk("prio_noack", hack, 0);
    @(negedge clk);
    chk("prio_ack", hack, 1);
    hreq = 0; hwe = 0;
    @(negedge clk);
    chk("full_fill_again", fill, 16);
    chk("full_grants", ngrant, 4);

    repeat (3) @(negedge clk);
    chk("host_q_empty", host_q.size(), 0);
    chk("load_q_empty", load_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
